// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD responder: oversamples sd_clk/CMD, decodes 48-bit command
// frames with CRC7 checking, and returns an R1-format response NCR clocks later.
module sd_cmd_responder #(
    parameter int NCR         = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sd_clk_in,
    input  logic        sd_cmd_in,
    output logic        sd_cmd_out,
    output logic        sd_cmd_oe,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        cmd_crc_err,
    output logic        cmd_frame_err,
    input  logic [31:0] resp_status,
    input  logic        resp_suppress,
    output logic        busy
);
    typedef enum logic [2:0] {ST_IDLE, ST_RX, ST_CHECK, ST_WAIT_NCR, ST_TX} state_t;

    localparam logic [6:0] NCR_CNT = 7'(NCR);

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    logic [SYNC_STAGES-1:0] clk_sync_reg, clk_sync_next;
    logic [SYNC_STAGES-1:0] cmd_sync_reg, cmd_sync_next;
    logic                   clk_prev_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_in
                assign clk_sync_next[gi] = sd_clk_in;
                assign cmd_sync_next[gi] = sd_cmd_in;
            end else begin : g_chain
                assign clk_sync_next[gi] = clk_sync_reg[gi-1];
                assign cmd_sync_next[gi] = cmd_sync_reg[gi-1];
            end
        end
    endgenerate

    logic clk_s, cmd_s, rise, fall;
    assign clk_s = clk_sync_reg[SYNC_STAGES-1];
    assign cmd_s = cmd_sync_reg[SYNC_STAGES-1];
    assign rise  = clk_s & ~clk_prev_reg;
    assign fall  = ~clk_s & clk_prev_reg;

    state_t        state_reg, state_next;
    logic [46:0]   rx_reg, rx_next;          // frame bits 46..0; start bit is implied
    logic [5:0]    bit_cnt_reg, bit_cnt_next;
    logic [6:0]    crc_reg, crc_next;
    logic [6:0]    ncr_cnt_reg, ncr_cnt_next;
    logic [39:0]   tx_reg, tx_next;
    logic [5:0]    idx_reg, idx_next;
    logic [31:0]   arg_reg, arg_next;
    logic          valid_reg, valid_next;
    logic          crc_err_reg, crc_err_next;
    logic          frame_err_reg, frame_err_next;
    logic          out_reg, out_next;
    logic          oe_reg, oe_next;

    always_comb begin
        state_next     = state_reg;
        rx_next        = rx_reg;
        bit_cnt_next   = bit_cnt_reg;
        crc_next       = crc_reg;
        ncr_cnt_next   = ncr_cnt_reg;
        tx_next        = tx_reg;
        idx_next       = idx_reg;
        arg_next       = arg_reg;
        valid_next     = 1'b0;
        crc_err_next   = 1'b0;
        frame_err_next = 1'b0;
        out_next       = out_reg;
        oe_next        = oe_reg;
        case (state_reg)
            ST_IDLE: begin
                if (rise && !cmd_s) begin
                    rx_next      = '0;
                    bit_cnt_next = 6'd1;
                    crc_next     = '0;
                    state_next   = ST_RX;
                end
            end
            ST_RX: begin
                if (rise) begin
                    rx_next      = {rx_reg[45:0], cmd_s};
                    bit_cnt_next = bit_cnt_reg + 6'd1;
                    // Bit count c receives frame bit 47-c; only bits 46..8 feed the CRC.
                    if (bit_cnt_reg < 6'd40) begin
                        crc_next = crc7_step(crc_reg, cmd_s);
                    end
                    if (bit_cnt_reg == 6'd47) begin
                        state_next = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                state_next = ST_IDLE;
                if (!rx_reg[46] || !rx_reg[0]) begin
                    frame_err_next = 1'b1;
                end else if (rx_reg[7:1] != crc_reg) begin
                    crc_err_next = 1'b1;
                end else begin
                    valid_next   = 1'b1;
                    idx_next     = rx_reg[45:40];
                    arg_next     = rx_reg[39:8];
                    tx_next      = {2'b00, rx_reg[45:40], resp_status};
                    ncr_cnt_next = '0;
                    if (!resp_suppress) begin
                        state_next = ST_WAIT_NCR;
                    end
                end
            end
            ST_WAIT_NCR: begin
                if (rise && ncr_cnt_reg != NCR_CNT) begin
                    ncr_cnt_next = ncr_cnt_reg + 7'd1;
                end
                if (fall && ncr_cnt_reg == NCR_CNT) begin
                    oe_next      = 1'b1;
                    out_next     = tx_reg[39];
                    tx_next      = {tx_reg[38:0], 1'b0};
                    crc_next     = crc7_step(7'd0, tx_reg[39]);
                    bit_cnt_next = 6'd1;
                    state_next   = ST_TX;
                end
            end
            ST_TX: begin
                if (fall) begin
                    bit_cnt_next = bit_cnt_reg + 6'd1;
                    if (bit_cnt_reg == 6'd48) begin
                        oe_next    = 1'b0;
                        out_next   = 1'b1;
                        state_next = ST_IDLE;
                    end else if (bit_cnt_reg < 6'd40) begin
                        out_next = tx_reg[39];
                        tx_next  = {tx_reg[38:0], 1'b0};
                        crc_next = crc7_step(crc_reg, tx_reg[39]);
                    end else if (bit_cnt_reg < 6'd47) begin
                        out_next = crc_reg[6];
                        crc_next = {crc_reg[5:0], 1'b0};
                    end else begin
                        out_next = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_sync_reg  <= '1;
            cmd_sync_reg  <= '1;
            clk_prev_reg  <= 1'b1;
            state_reg     <= ST_IDLE;
            rx_reg        <= '0;
            bit_cnt_reg   <= '0;
            crc_reg       <= '0;
            ncr_cnt_reg   <= '0;
            tx_reg        <= '0;
            idx_reg       <= '0;
            arg_reg       <= '0;
            valid_reg     <= 1'b0;
            crc_err_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            out_reg       <= 1'b1;
            oe_reg        <= 1'b0;
        end else begin
            clk_sync_reg  <= clk_sync_next;
            cmd_sync_reg  <= cmd_sync_next;
            clk_prev_reg  <= clk_s;
            state_reg     <= state_next;
            rx_reg        <= rx_next;
            bit_cnt_reg   <= bit_cnt_next;
            crc_reg       <= crc_next;
            ncr_cnt_reg   <= ncr_cnt_next;
            tx_reg        <= tx_next;
            idx_reg       <= idx_next;
            arg_reg       <= arg_next;
            valid_reg     <= valid_next;
            crc_err_reg   <= crc_err_next;
            frame_err_reg <= frame_err_next;
            out_reg       <= out_next;
            oe_reg        <= oe_next;
        end
    end

    assign sd_cmd_out    = out_reg;
    assign sd_cmd_oe     = oe_reg;
    assign cmd_valid     = valid_reg;
    assign cmd_index     = idx_reg;
    assign cmd_arg       = arg_reg;
    assign cmd_crc_err   = crc_err_reg;
    assign cmd_frame_err = frame_err_reg;
    assign busy          = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_sd_cmd_responder.sv
// Bench for sd_cmd_responder: host-side frame driver, frame-level reference model
// and a per-cycle compare process; covers NCR=2 and NCR=64 instances.
module tb_sd_cmd_responder;
    localparam int K_VALID = 0;
    localparam int K_CRC   = 1;
    localparam int K_FRAME = 2;
    localparam int K_NONE  = 3;

    logic clk = 1'b0;
    logic sd_clk = 1'b0;
    logic rst = 1'b0;
    logic sel64 = 1'b0;
    logic host_cmd = 1'b1;
    logic [31:0] resp_status = '0;
    logic resp_suppress = 1'b0;

    logic rst_a, rst_b;
    assign rst_a = sel64 ? 1'b0 : rst;
    assign rst_b = sel64 ? rst : 1'b0;

    logic out_a, oe_a, valid_a, crc_a, frame_a, busy_a;
    logic out_b, oe_b, valid_b, crc_b, frame_b, busy_b;
    logic [5:0] idx_a, idx_b;
    logic [31:0] arg_a, arg_b;

    sd_cmd_responder #(.NCR(2), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst_a), .sd_clk_in(sd_clk), .sd_cmd_in(host_cmd),
        .sd_cmd_out(out_a), .sd_cmd_oe(oe_a), .cmd_valid(valid_a),
        .cmd_index(idx_a), .cmd_arg(arg_a), .cmd_crc_err(crc_a),
        .cmd_frame_err(frame_a), .resp_status(resp_status),
        .resp_suppress(resp_suppress), .busy(busy_a)
    );

    sd_cmd_responder #(.NCR(64), .SYNC_STAGES(2)) dut64 (
        .clk(clk), .rst(rst_b), .sd_clk_in(sd_clk), .sd_cmd_in(host_cmd),
        .sd_cmd_out(out_b), .sd_cmd_oe(oe_b), .cmd_valid(valid_b),
        .cmd_index(idx_b), .cmd_arg(arg_b), .cmd_crc_err(crc_b),
        .cmd_frame_err(frame_b), .resp_status(resp_status),
        .resp_suppress(resp_suppress), .busy(busy_b)
    );

    logic obs_out, obs_oe, obs_valid, obs_crc, obs_frame, obs_busy;
    logic [5:0] obs_idx;
    logic [31:0] obs_arg;
    assign obs_out   = sel64 ? out_b   : out_a;
    assign obs_oe    = sel64 ? oe_b    : oe_a;
    assign obs_valid = sel64 ? valid_b : valid_a;
    assign obs_crc   = sel64 ? crc_b   : crc_a;
    assign obs_frame = sel64 ? frame_b : frame_a;
    assign obs_busy  = sel64 ? busy_b  : busy_a;
    assign obs_idx   = sel64 ? idx_b   : idx_a;
    assign obs_arg   = sel64 ? arg_b   : arg_a;

    always #5 clk = ~clk;
    initial begin
        #2;
        forever #80 sd_clk = ~sd_clk;
    end

    int checks = 0;
    int failures = 0;

    // Expected-outcome scoreboards, filled by the host driver, drained by the compare process.
    int          ev_kind [64];
    logic [5:0]  ev_idx  [64];
    logic [31:0] ev_arg  [64];
    int          ev_wr = 0, ev_rd = 0;
    logic [47:0] rs_val  [16];
    int          rs_start[16];
    int          rs_wr = 0, rs_rd = 0;

    logic [5:0]  m_idx = '0;
    logic [31:0] m_arg = '0;
    logic [47:0] cur_resp = '0;
    logic        in_resp = 1'b0;
    int          bitpos = 0;
    int          rise_cnt = 0;
    logic        sclk_prev = 1'b0;
    logic        rst_q = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] m_crc7(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] m;
        m = {2'b01, idx, arg};
        return {m, m_crc7(m), 1'b1};
    endfunction

    function automatic logic [47:0] mk_resp(input logic [5:0] idx, input logic [31:0] st);
        logic [39:0] m;
        m = {2'b00, idx, st};
        return {m, m_crc7(m), 1'b1};
    endfunction

    function automatic int model_kind(input logic [47:0] f);
        if (!f[46] || !f[0]) return K_FRAME;
        if (f[7:1] != m_crc7(f[47:8])) return K_CRC;
        return K_VALID;
    endfunction

    task automatic send_frame(input logic [47:0] f, input logic [31:0] st, input logic supp);
        int kind;
        int end_rise;
        int ncr_cur;
        resp_status   = st;
        resp_suppress = supp;
        kind    = model_kind(f);
        ncr_cur = sel64 ? 64 : 2;
        for (int i = 47; i >= 0; i--) begin
            @(negedge sd_clk);
            host_cmd = f[i];
        end
        end_rise = rise_cnt + 1;
        ev_kind[ev_wr % 64] = kind;
        ev_idx[ev_wr % 64]  = f[45:40];
        ev_arg[ev_wr % 64]  = f[39:8];
        if (kind == K_VALID && !supp) begin
            rs_val[rs_wr % 16]   = mk_resp(f[45:40], st);
            rs_start[rs_wr % 16] = end_rise + ncr_cur + 1;
            rs_wr++;
        end
        ev_wr++;
        @(negedge sd_clk);
        host_cmd = 1'b1;
        $display("txn frame=%012h status=%08h suppress=%0d ncr=%0d expect_kind=%0d",
                 f, st, supp, ncr_cur, kind);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (n < 4000 && !(ev_rd == ev_wr && rs_rd == rs_wr && !in_resp && obs_busy == 1'b0)) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle"}, 64'(ev_rd == ev_wr && rs_rd == rs_wr && !in_resp && obs_busy == 1'b0), 64'd1);
    endtask

    task automatic compare_loop();
        int npulse;
        int kind_act;
        int kind_exp;
        int start_exp;
        forever begin
            @(posedge clk);
            rst_q = rst;
            @(negedge clk);
            if (!rst_q) begin
                if (in_resp) begin
                    chk("abort_oe", 64'(obs_oe), 64'd0);
                    chk("abort_out", 64'(obs_out), 64'd1);
                    chk("abort_busy", 64'(obs_busy), 64'd0);
                end
                in_resp = 1'b0;
                ev_rd   = ev_wr;
                rs_rd   = rs_wr;
                m_idx   = '0;
                m_arg   = '0;
            end
            npulse = int'(obs_valid) + int'(obs_crc) + int'(obs_frame);
            chk("pulse_excl", 64'(npulse <= 1), 64'd1);
            if (npulse != 0) begin
                kind_act = obs_valid ? K_VALID : (obs_crc ? K_CRC : K_FRAME);
                kind_exp = (ev_rd == ev_wr) ? K_NONE : ev_kind[ev_rd % 64];
                chk("pulse_kind", 64'(kind_act), 64'(kind_exp));
                if (ev_rd != ev_wr) begin
                    if (kind_exp == K_VALID) begin
                        m_idx = ev_idx[ev_rd % 64];
                        m_arg = ev_arg[ev_rd % 64];
                    end
                    ev_rd++;
                end
            end
            chk("cmd_index", 64'(obs_idx), 64'(m_idx));
            chk("cmd_arg", 64'(obs_arg), 64'(m_arg));
            if (!in_resp && rs_rd == rs_wr) chk("oe_idle", 64'(obs_oe), 64'd0);
            if (sd_clk && !sclk_prev) begin
                rise_cnt++;
                if (rst_q) begin
                    if (in_resp && bitpos == 48) begin
                        chk("resp_release_oe", 64'(obs_oe), 64'd0);
                        chk("resp_release_out", 64'(obs_out), 64'd1);
                        in_resp = 1'b0;
                    end else if (in_resp) begin
                        chk("resp_oe_hold", 64'(obs_oe), 64'd1);
                        chk("resp_bit", 64'(obs_out), 64'(cur_resp[47 - bitpos]));
                        bitpos++;
                    end else if (obs_oe) begin
                        start_exp = (rs_rd == rs_wr) ? -1 : rs_start[rs_rd % 16];
                        chk("resp_start_rise", 64'(rise_cnt), 64'(start_exp));
                        if (rs_rd != rs_wr) begin
                            cur_resp = rs_val[rs_rd % 16];
                            rs_rd++;
                        end
                        chk("resp_bit", 64'(obs_out), 64'(cur_resp[47]));
                        in_resp = 1'b1;
                        bitpos  = 1;
                    end
                end
            end
            sclk_prev = sd_clk;
        end
    endtask

    initial begin
        int n;
        logic [47:0] f;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_oe", 64'(obs_oe), 64'd0);
        chk("reset_out", 64'(obs_out), 64'd1);
        chk("reset_busy", 64'(obs_busy), 64'd0);
        chk("reset_valid", 64'(obs_valid), 64'd0);
        chk("reset_index", 64'(obs_idx), 64'd0);
        chk("reset_arg", 64'(obs_arg), 64'd0);
        chk("pin_cmd0", 64'(mk_frame(6'd0, 32'h0)), 64'h4000_0000_0095);
        chk("pin_cmd55", 64'(mk_frame(6'd55, 32'h0)), 64'h7700_0000_0065);
        chk("pin_cmd8", 64'(mk_frame(6'd8, 32'h1AA)), 64'h4800_0001_AA87);
        chk("pin_r1_cmd55", 64'(mk_resp(6'd55, 32'h120)), 64'h3700_0001_2083);
        rst = 1'b1;
        sclk_prev = sd_clk;
        fork
            compare_loop();
        join_none

        send_frame(48'h4000_0000_0095, 32'h0, 1'b1);
        wait_idle("cmd0");
        chk("cmd0_busy", 64'(obs_busy), 64'd0);
        chk("cmd0_oe", 64'(obs_oe), 64'd0);

        send_frame(48'h7700_0000_0065, 32'h0000_0120, 1'b0);
        wait_idle("cmd55");
        chk("cmd55_index", 64'(obs_idx), 64'd55);

        f = mk_frame(6'd17, 32'h0000_1000) ^ 48'h8;
        send_frame(f, 32'h0000_0900, 1'b0);
        wait_idle("cmd17_crc");
        chk("cmd17_index_kept", 64'(obs_idx), 64'd55);

        f = 48'h4800_0001_AA87 & ~48'h1;
        send_frame(f, 32'h0, 1'b0);
        wait_idle("cmd8_end");
        f = 48'h4800_0001_AA87 & ~(48'h1 << 46);
        send_frame(f, 32'h0, 1'b0);
        wait_idle("cmd8_tbit");
        send_frame(48'h4800_0001_AA87, 32'h0000_01AA, 1'b0);
        wait_idle("cmd8_good");

        send_frame(48'h7700_0000_0065, 32'h0000_0120, 1'b0);
        n = 0;
        while (!(in_resp && bitpos >= 20) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("tx_bit20_reached", 64'(in_resp && bitpos >= 20), 64'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_edge_oe", 64'(obs_oe), 64'd0);
        chk("rst_edge_out", 64'(obs_out), 64'd1);
        chk("rst_edge_busy", 64'(obs_busy), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        send_frame(48'h4000_0000_0095, 32'h0, 1'b1);
        wait_idle("cmd0_after_rst");
        chk("cmd0_after_rst_index", 64'(obs_idx), 64'd0);

        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        sel64 = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(48'h7700_0000_0065, 32'h0000_0120, 1'b0);
        repeat (10) @(negedge sd_clk);
        host_cmd = 1'b0;
        repeat (3) @(negedge sd_clk);
        host_cmd = 1'b1;
        wait_idle("ncr64_first");
        send_frame(48'h7700_0000_0065, 32'h0000_0920, 1'b0);
        wait_idle("ncr64_second");
        chk("ncr64_index", 64'(obs_idx), 64'd55);

        repeat (20) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sd_cmd_responder.md
Name: sd_cmd_responder

Overview:
Card-side responder for the SD CMD line, the counterpart to the host-side sd_interface command initiator. It oversamples the host-driven sd_clk and CMD line and deserialises 48-bit command frames. It checks the frame's CRC7, start, transmission and end bits, presents the decoded command to card logic, and then serialises a 48-bit R1-format response back onto CMD. It is used as a bench/emulation card model and as the front end of the card-emulation path.

Parameters:
NCR, 2, number of sd_clk rising edges between command end bit and response start bit (legal 2..64)
SYNC_STAGES, 2, synchroniser depth on sd_clk_in and sd_cmd_in

Ports:
clk  input  1  system clock; must be at least 8x sd_clk frequency
rst  input  1  synchronous, active-low reset
sd_clk_in  input  1  SD clock from host, asynchronous to clk
sd_cmd_in  input  1  CMD line as seen by card
sd_cmd_out  output  1  CMD value driven by card
sd_cmd_oe  output  1  1 = card drives CMD (pad tri-state enable)
cmd_valid  output  1  one-clk pulse: good command received
cmd_index  output  6  command index of last good command
cmd_arg  output  32  argument of last good command
cmd_crc_err  output  1  one-clk pulse: CRC7 mismatch
cmd_frame_err  output  1  one-clk pulse: transmission bit 0 or end bit 0
resp_status  input  32  card status for the response, sampled in CHECK
resp_suppress  input  1  sampled in CHECK; 1 = no response (e.g. CMD0)
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst low at a clk edge) sets: sd_cmd_out=1, sd_cmd_oe=0, cmd_valid=0, cmd_crc_err=0, cmd_frame_err=0, cmd_index=0, cmd_arg=0, busy=0, state=IDLE, synchronisers=1. Reset mid-frame or mid-response aborts immediately and releases CMD on the same edge.
- sd_clk_in and sd_cmd_in each pass through SYNC_STAGES flops. Rise and fall events are single-clk pulses from the synced clock versus its previous value. CMD is sampled on rise events and driven on fall events.
- CRC7 uses polynomial x^7+x^3+1, initial value 0, computed MSB-first over frame bits 47..8. It is computed serially during RX/TX.
- IDLE: on a rise event with sampled CMD=0, capture bit 47, clear bit counter and CRC, go to RX.
- RX: shift one bit per rise event until 48 bits are held, then go to CHECK.
- CHECK (exactly one clk):
  - If bit46 != 1 or bit0 != 1: pulse cmd_frame_err, go to IDLE.
  - Else if received CRC (bits 7..1) != computed: pulse cmd_crc_err, go to IDLE. cmd_index/cmd_arg are unchanged on either error.
  - Else: load cmd_index=bits45..40 and cmd_arg=bits39..8, pulse cmd_valid in the following clk, and latch resp_status and resp_suppress.
  - If resp_suppress=1: go to IDLE. Otherwise load the TX shifter with {0,0,cmd_index,resp_status} and go to WAIT_NCR.
- WAIT_NCR: count rise events. After the NCR-th, on the next fall event assert sd_cmd_oe=1 and sd_cmd_out=0 (start bit), then go to TX.
- TX: on each subsequent fall event drive the next bit. Bits 7..1 are the CRC7 computed over the transmitted bits 47..8; bit 0 = 1.
  - On the fall event after the end bit, sd_cmd_oe=0 and sd_cmd_out=1, go to IDLE.
  - sd_cmd_in is ignored during WAIT_NCR and TX, so a host start bit there is not decoded.
- cmd_valid, cmd_crc_err and cmd_frame_err are mutually exclusive. They never assert outside the CHECK+1 cycle.
- If sd_clk stops mid-frame, the block holds state indefinitely. There is no timeout; the host recovers by reset.
- A new frame may begin on the first rise event after returning to IDLE.

Test Plan:
- CMD0 frame 0x40_00000000_95 with resp_suppress=1 -> cmd_valid pulse, cmd_index=0, cmd_arg=0; sd_cmd_oe stays 0; busy returns to 0 after CHECK.
- CMD55 frame 0x77_00000000_65, resp_status=0x00000120, NCR=2 -> cmd_index=55; start bit driven on the fall after the 2nd rise post end-bit; serial response 0x37_00000120_83; oe drops after 48 bits.
- CMD17 frame 0x51_00001000_XX with one CRC bit flipped -> cmd_crc_err pulse, no cmd_valid, cmd_index/cmd_arg keep prior values, no response.
- CMD8 frame 0x48_000001AA_87 with end bit forced 0 -> cmd_frame_err pulse only; with transmission bit forced 0 -> cmd_frame_err pulse only.
- rst deasserted-low during TX bit 20 of the CMD55 response -> same clk edge sd_cmd_oe=0, sd_cmd_out=1, busy=0; a following CMD0 frame decodes correctly.
- NCR=64, back-to-back CMD55 frames with host start bit injected during WAIT_NCR -> injected bits ignored; response begins exactly after 64 rise events; second frame is decoded after the response completes.
